// File: rtl/riscv_core_reorder_buffer.sv
// riscv_core_reorder_buffer
//   Reorder buffer for the dual-issue, in-order-commit core. Allocates up to
//   two entries per cycle in program order, accepts out-of-order result
//   writeback from pipelines A and B, and retires up to two completed entries
//   per cycle in order.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   rob_alloc_*             issue-side allocation (req/wen/waddr for ir0, ir1),
//                           rdy and the slots handed back to issue
//   rob_fill_*_A / _B       writeback from pipelines A and B (slot + data)
//   rob_commit_wen/slot_k   retiring entries, to the scoreboard
//   rob_commit_rf_*_k       register-file write ports for retiring entries
//   rob_count               occupied entries
module riscv_core_reorder_buffer #(
    parameter int ENTRIES = 32,
    parameter int SLOT_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              rob_alloc_req_0,
    input  logic              rob_alloc_wen_0,
    input  logic [4:0]        rob_alloc_waddr_0,
    input  logic              rob_alloc_req_1,
    input  logic              rob_alloc_wen_1,
    input  logic [4:0]        rob_alloc_waddr_1,
    output logic              rob_alloc_rdy,
    output logic [SLOT_W-1:0] rob_alloc_slot_0,
    output logic [SLOT_W-1:0] rob_alloc_slot_1,

    input  logic              rob_fill_wen_A,
    input  logic [SLOT_W-1:0] rob_fill_slot_A,
    input  logic [DATA_W-1:0] rob_fill_data_A,
    input  logic              rob_fill_wen_B,
    input  logic [SLOT_W-1:0] rob_fill_slot_B,
    input  logic [DATA_W-1:0] rob_fill_data_B,

    output logic              rob_commit_wen_1,
    output logic [SLOT_W-1:0] rob_commit_slot_1,
    output logic              rob_commit_wen_2,
    output logic [SLOT_W-1:0] rob_commit_slot_2,
    output logic              rob_commit_rf_wen_1,
    output logic [4:0]        rob_commit_rf_waddr_1,
    output logic [DATA_W-1:0] rob_commit_rf_wdata_1,
    output logic              rob_commit_rf_wen_2,
    output logic [4:0]        rob_commit_rf_waddr_2,
    output logic [DATA_W-1:0] rob_commit_rf_wdata_2,

    output logic [SLOT_W:0]   rob_count
);

    logic [SLOT_W-1:0] head, tail, head_p1;
    logic [SLOT_W:0]   count;

    // valid is the only per-entry bit that needs reset; the payload is
    // always qualified by valid before it is used.
    logic [ENTRIES-1:0] valid;
    logic [ENTRIES-1:0] pending;
    logic [ENTRIES-1:0] rf_wen;
    logic [4:0]         rf_waddr [ENTRIES];
    logic [DATA_W-1:0]  data     [ENTRIES];

    logic              do_alloc_0, do_alloc_1;
    logic              fill_a_ok, fill_b_ok;
    logic [SLOT_W:0]   n_alloc, n_commit;

    assign head_p1 = head + SLOT_W'(1);

    // Space check uses registered count only, so a commit in the same
    // cycle never frees room for an allocation.
    assign rob_alloc_rdy    = (count <= (SLOT_W+1)'(ENTRIES - 2));
    assign rob_alloc_slot_0 = tail;
    assign rob_alloc_slot_1 = rob_alloc_req_0 ? tail + SLOT_W'(1) : tail;

    assign do_alloc_0 = rob_alloc_rdy & rob_alloc_req_0;
    assign do_alloc_1 = rob_alloc_rdy & rob_alloc_req_1;

    // Writebacks to entries that are not live (e.g. stale after a flush)
    // are dropped.
    assign fill_a_ok = rob_fill_wen_A & valid[rob_fill_slot_A];
    assign fill_b_ok = rob_fill_wen_B & valid[rob_fill_slot_B];

    assign rob_commit_wen_1  = valid[head] & ~pending[head];
    assign rob_commit_wen_2  = rob_commit_wen_1 & valid[head_p1] & ~pending[head_p1];
    assign rob_commit_slot_1 = head;
    assign rob_commit_slot_2 = head_p1;

    assign rob_commit_rf_wen_1   = rob_commit_wen_1 & rf_wen[head];
    assign rob_commit_rf_waddr_1 = rf_waddr[head];
    assign rob_commit_rf_wdata_1 = data[head];
    assign rob_commit_rf_wen_2   = rob_commit_wen_2 & rf_wen[head_p1];
    assign rob_commit_rf_waddr_2 = rf_waddr[head_p1];
    assign rob_commit_rf_wdata_2 = data[head_p1];

    assign n_alloc  = (SLOT_W+1)'(do_alloc_0) + (SLOT_W+1)'(do_alloc_1);
    assign n_commit = (SLOT_W+1)'(rob_commit_wen_1) + (SLOT_W+1)'(rob_commit_wen_2);

    assign rob_count = count;

    // Pointers, occupancy and entry validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (rob_commit_wen_1) valid[head]    <= 1'b0;
            if (rob_commit_wen_2) valid[head_p1] <= 1'b0;
            // Allocated slots are always free (rdy guarantees two), so they
            // never collide with the retiring slots above.
            if (do_alloc_0) valid[rob_alloc_slot_0] <= 1'b1;
            if (do_alloc_1) valid[rob_alloc_slot_1] <= 1'b1;
            head  <= head + n_commit[SLOT_W-1:0];
            tail  <= tail + n_alloc[SLOT_W-1:0];
            count <= count + n_alloc - n_commit;
        end
    end

    // Entry payload. A fill only ever targets a live entry and an alloc only
    // a free one, so the two never write the same slot in one cycle.
    always_ff @(posedge clk) begin
        if (do_alloc_0) begin
            pending[rob_alloc_slot_0]  <= 1'b1;
            rf_wen[rob_alloc_slot_0]   <= rob_alloc_wen_0;
            rf_waddr[rob_alloc_slot_0] <= rob_alloc_waddr_0;
        end
        if (do_alloc_1) begin
            pending[rob_alloc_slot_1]  <= 1'b1;
            rf_wen[rob_alloc_slot_1]   <= rob_alloc_wen_1;
            rf_waddr[rob_alloc_slot_1] <= rob_alloc_waddr_1;
        end
        // B first so that A takes priority on a same-slot collision.
        if (fill_b_ok) begin
            pending[rob_fill_slot_B] <= 1'b0;
            data[rob_fill_slot_B]    <= rob_fill_data_B;
        end
        if (fill_a_ok) begin
            pending[rob_fill_slot_A] <= 1'b0;
            data[rob_fill_slot_A]    <= rob_fill_data_A;
        end
    end

endmodule

// File: tb/tb_riscv_core_reorder_buffer.sv
// tb_riscv_core_reorder_buffer
//   Directed scenarios plus a randomized run for riscv_core_reorder_buffer,
//   checked against a queue-based model of the in-order buffer.
module tb_riscv_core_reorder_buffer;

    localparam int ENTRIES = 32;
    localparam int SLOT_W  = 5;
    localparam int DATA_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              rob_alloc_req_0, rob_alloc_wen_0, rob_alloc_req_1, rob_alloc_wen_1;
    logic [4:0]        rob_alloc_waddr_0, rob_alloc_waddr_1;
    logic              rob_alloc_rdy;
    logic [SLOT_W-1:0] rob_alloc_slot_0, rob_alloc_slot_1;
    logic              rob_fill_wen_A, rob_fill_wen_B;
    logic [SLOT_W-1:0] rob_fill_slot_A, rob_fill_slot_B;
    logic [DATA_W-1:0] rob_fill_data_A, rob_fill_data_B;
    logic              rob_commit_wen_1, rob_commit_wen_2;
    logic [SLOT_W-1:0] rob_commit_slot_1, rob_commit_slot_2;
    logic              rob_commit_rf_wen_1, rob_commit_rf_wen_2;
    logic [4:0]        rob_commit_rf_waddr_1, rob_commit_rf_waddr_2;
    logic [DATA_W-1:0] rob_commit_rf_wdata_1, rob_commit_rf_wdata_2;
    logic [SLOT_W:0]   rob_count;

    riscv_core_reorder_buffer #(.ENTRIES(ENTRIES), .SLOT_W(SLOT_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .rob_alloc_req_0(rob_alloc_req_0), .rob_alloc_wen_0(rob_alloc_wen_0),
        .rob_alloc_waddr_0(rob_alloc_waddr_0),
        .rob_alloc_req_1(rob_alloc_req_1), .rob_alloc_wen_1(rob_alloc_wen_1),
        .rob_alloc_waddr_1(rob_alloc_waddr_1),
        .rob_alloc_rdy(rob_alloc_rdy), .rob_alloc_slot_0(rob_alloc_slot_0),
        .rob_alloc_slot_1(rob_alloc_slot_1),
        .rob_fill_wen_A(rob_fill_wen_A), .rob_fill_slot_A(rob_fill_slot_A),
        .rob_fill_data_A(rob_fill_data_A),
        .rob_fill_wen_B(rob_fill_wen_B), .rob_fill_slot_B(rob_fill_slot_B),
        .rob_fill_data_B(rob_fill_data_B),
        .rob_commit_wen_1(rob_commit_wen_1), .rob_commit_slot_1(rob_commit_slot_1),
        .rob_commit_wen_2(rob_commit_wen_2), .rob_commit_slot_2(rob_commit_slot_2),
        .rob_commit_rf_wen_1(rob_commit_rf_wen_1), .rob_commit_rf_waddr_1(rob_commit_rf_waddr_1),
        .rob_commit_rf_wdata_1(rob_commit_rf_wdata_1),
        .rob_commit_rf_wen_2(rob_commit_rf_wen_2), .rob_commit_rf_waddr_2(rob_commit_rf_waddr_2),
        .rob_commit_rf_wdata_2(rob_commit_rf_wdata_2),
        .rob_count(rob_count)
    );

    always #5 clk = ~clk;

    // Same-slot writeback from both pipelines is illegal stimulus.
    always @(posedge clk)
        if (!reset && rob_fill_wen_A && rob_fill_wen_B)
            assert (rob_fill_slot_A != rob_fill_slot_B)
            else $error("both pipelines wrote back slot %0d", rob_fill_slot_A);

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: program-ordered queue of live slots plus per-slot payload.
    int       q[$];
    int       m_head, m_tail;
    bit       m_inq    [ENTRIES];
    bit       m_filled [ENTRIES];
    bit       m_wen    [ENTRIES];
    bit [4:0] m_waddr  [ENTRIES];
    bit [31:0] m_data  [ENTRIES];

    task automatic push_entry(input bit w, input bit [4:0] a);
        m_inq[m_tail] = 1'b1; m_filled[m_tail] = 1'b0;
        m_wen[m_tail] = w;    m_waddr[m_tail]  = a;
        q.push_back(m_tail);
        m_tail = (m_tail + 1) % ENTRIES;
    endtask

    // Advance the model by one clock edge using the inputs applied before it.
    task automatic model_step();
        int c;
        bit rdy;
        if (reset) begin
            q.delete(); m_head = 0; m_tail = 0;
            for (int i = 0; i < ENTRIES; i++) m_inq[i] = 1'b0;
            return;
        end
        rdy = (q.size() <= ENTRIES - 2);
        c = 0;
        if (q.size() > 0 && m_filled[q[0]]) begin
            c = 1;
            if (q.size() > 1 && m_filled[q[1]]) c = 2;
        end
        if (rob_fill_wen_B && m_inq[rob_fill_slot_B]) begin
            m_filled[rob_fill_slot_B] = 1'b1; m_data[rob_fill_slot_B] = rob_fill_data_B;
        end
        if (rob_fill_wen_A && m_inq[rob_fill_slot_A]) begin
            m_filled[rob_fill_slot_A] = 1'b1; m_data[rob_fill_slot_A] = rob_fill_data_A;
        end
        repeat (c) begin
            m_inq[q[0]] = 1'b0;
            void'(q.pop_front());
            m_head = (m_head + 1) % ENTRIES;
        end
        if (rdy && rob_alloc_req_0) push_entry(rob_alloc_wen_0, rob_alloc_waddr_0);
        if (rdy && rob_alloc_req_1) push_entry(rob_alloc_wen_1, rob_alloc_waddr_1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        rob_alloc_req_0 = 0; rob_alloc_wen_0 = 0; rob_alloc_waddr_0 = 0;
        rob_alloc_req_1 = 0; rob_alloc_wen_1 = 0; rob_alloc_waddr_1 = 0;
        rob_fill_wen_A = 0; rob_fill_slot_A = 0; rob_fill_data_A = 0;
        rob_fill_wen_B = 0; rob_fill_slot_B = 0; rob_fill_data_B = 0;
    endtask

    task automatic alloc(input bit r0, input bit w0, input int a0,
                         input bit r1, input bit w1, input int a1);
        rob_alloc_req_0 = r0; rob_alloc_wen_0 = w0; rob_alloc_waddr_0 = 5'(a0);
        rob_alloc_req_1 = r1; rob_alloc_wen_1 = w1; rob_alloc_waddr_1 = 5'(a1);
    endtask

    task automatic fill_a(input int s, input bit [31:0] d);
        rob_fill_wen_A = 1; rob_fill_slot_A = 5'(s); rob_fill_data_A = d;
    endtask

    task automatic fill_b(input int s, input bit [31:0] d);
        rob_fill_wen_B = 1; rob_fill_slot_B = 5'(s); rob_fill_data_B = d;
    endtask

    task automatic test_reset();
        reset = 1; idle(); rob_alloc_req_0 = 1;
        tick(); tick();
        n_cmp++; if (rob_alloc_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", rob_alloc_rdy); end
        n_cmp++; if (rob_commit_wen_1 !== 1'b0 || rob_commit_wen_2 !== 1'b0) begin n_bad++; $display("FAIL reset_commit got %b%b want 00", rob_commit_wen_1, rob_commit_wen_2); end
        n_cmp++; if (rob_alloc_slot_0 !== 5'd0 || rob_alloc_slot_1 !== 5'd1) begin n_bad++; $display("FAIL reset_slots got %0d/%0d want 0/1", rob_alloc_slot_0, rob_alloc_slot_1); end
        n_cmp++; if (rob_count !== 6'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", rob_count); end
        reset = 0; idle(); #1;
        n_cmp++; if (rob_alloc_slot_1 !== 5'd0) begin n_bad++; $display("FAIL idle_slot1 got %0d want 0", rob_alloc_slot_1); end
    endtask

    task automatic test_pair_commit();
        alloc(1, 1, 5, 1, 1, 6); #1;
        n_cmp++; if (rob_alloc_slot_0 !== 5'd0 || rob_alloc_slot_1 !== 5'd1) begin n_bad++; $display("FAIL pair_slots got %0d/%0d want 0/1", rob_alloc_slot_0, rob_alloc_slot_1); end
        tick(); idle();
        n_cmp++; if (rob_count !== 6'd2) begin n_bad++; $display("FAIL pair_count got %0d want 2", rob_count); end
        fill_b(1, 32'hBEEF); tick(); idle();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rob_commit_wen_1 !== 1'b0) begin n_bad++; $display("FAIL pair_hold%0d got %b want 0", i, rob_commit_wen_1); end
            tick();
        end
        fill_a(0, 32'h1234); tick(); idle();
        n_cmp++; if (rob_commit_wen_1 !== 1'b1 || rob_commit_wen_2 !== 1'b1) begin n_bad++; $display("FAIL pair_wens got %b%b want 11", rob_commit_wen_1, rob_commit_wen_2); end
        n_cmp++; if (rob_commit_slot_1 !== 5'd0 || rob_commit_slot_2 !== 5'd1) begin n_bad++; $display("FAIL pair_cslots got %0d/%0d want 0/1", rob_commit_slot_1, rob_commit_slot_2); end
        n_cmp++; if (rob_commit_rf_waddr_1 !== 5'd5 || rob_commit_rf_waddr_2 !== 5'd6) begin n_bad++; $display("FAIL pair_waddr got %0d/%0d want 5/6", rob_commit_rf_waddr_1, rob_commit_rf_waddr_2); end
        n_cmp++; if (rob_commit_rf_wdata_1 !== 32'h1234 || rob_commit_rf_wdata_2 !== 32'hBEEF) begin n_bad++; $display("FAIL pair_wdata got %h/%h want 1234/beef", rob_commit_rf_wdata_1, rob_commit_rf_wdata_2); end
        tick();
        n_cmp++; if (rob_count !== 6'd0) begin n_bad++; $display("FAIL pair_drain got %0d want 0", rob_count); end
    endtask

    task automatic test_single_alloc();
        alloc(0, 0, 0, 1, 0, 7); #1;
        n_cmp++; if (rob_alloc_slot_1 !== 5'd2) begin n_bad++; $display("FAIL single_slot got %0d want 2", rob_alloc_slot_1); end
        tick(); idle();
        n_cmp++; if (rob_count !== 6'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", rob_count); end
        fill_a(2, 32'hA5A5); tick(); idle();
        n_cmp++; if (rob_commit_wen_1 !== 1'b1 || rob_commit_rf_wen_1 !== 1'b0 || rob_commit_wen_2 !== 1'b0) begin n_bad++; $display("FAIL single_nowen got wen1=%b rfwen1=%b wen2=%b want 1/0/0", rob_commit_wen_1, rob_commit_rf_wen_1, rob_commit_wen_2); end
        tick();
        n_cmp++; if (rob_commit_slot_1 !== 5'd3 || rob_count !== 6'd0) begin n_bad++; $display("FAIL single_head got head=%0d count=%0d want 3/0", rob_commit_slot_1, rob_count); end
    endtask

    task automatic test_full();
        int snap[$];
        alloc(1, 1, 1, 1, 0, 2);
        repeat (15) tick();
        idle();
        n_cmp++; if (rob_count !== 6'd30 || rob_alloc_rdy !== 1'b1) begin n_bad++; $display("FAIL full30 got count=%0d rdy=%b want 30/1", rob_count, rob_alloc_rdy); end
        alloc(1, 1, 3, 0, 0, 0); tick(); idle();
        n_cmp++; if (rob_count !== 6'd31 || rob_alloc_rdy !== 1'b0) begin n_bad++; $display("FAIL full31 got count=%0d rdy=%b want 31/0", rob_count, rob_alloc_rdy); end
        alloc(1, 1, 4, 0, 0, 0); tick(); idle();
        n_cmp++; if (rob_count !== 6'd31 || rob_alloc_slot_0 !== 5'd2) begin n_bad++; $display("FAIL full_ignored got count=%0d tail=%0d want 31/2", rob_count, rob_alloc_slot_0); end
        fill_a(3, 32'h33); tick(); idle();
        n_cmp++; if (rob_commit_wen_1 !== 1'b1 || rob_commit_wen_2 !== 1'b0 || rob_commit_slot_1 !== 5'd3) begin n_bad++; $display("FAIL full_commit got wen=%b%b slot=%0d want 10/3", rob_commit_wen_1, rob_commit_wen_2, rob_commit_slot_1); end
        tick();
        n_cmp++; if (rob_count !== 6'd30 || rob_alloc_rdy !== 1'b1) begin n_bad++; $display("FAIL full_free got count=%0d rdy=%b want 30/1", rob_count, rob_alloc_rdy); end
        snap = q;
        foreach (snap[i]) begin fill_a(snap[i], $urandom()); tick(); end
        idle();
        for (int k = 0; k < 40 && rob_count != 0; k++) tick();
        n_cmp++; if (rob_count !== 6'd0) begin n_bad++; $display("FAIL full_drain got %0d want 0 within bound", rob_count); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 64 && m_tail != ENTRIES - 1; k++) begin
            alloc(1, 1, k, 0, 0, 0); tick(); idle();
            fill_a(q[q.size()-1], 32'(k)); tick(); idle();
            tick();
        end
        n_cmp++; if (rob_count !== 6'd0 || rob_alloc_slot_0 !== 5'd31) begin n_bad++; $display("FAIL wrap_prep got count=%0d tail=%0d want 0/31", rob_count, rob_alloc_slot_0); end
        alloc(1, 1, 11, 1, 1, 12); #1;
        n_cmp++; if (rob_alloc_slot_0 !== 5'd31 || rob_alloc_slot_1 !== 5'd0) begin n_bad++; $display("FAIL wrap_slots got %0d/%0d want 31/0", rob_alloc_slot_0, rob_alloc_slot_1); end
        tick(); idle();
        fill_a(31, 32'hF00D); fill_b(0, 32'hCAFE); tick(); idle();
        n_cmp++; if (rob_commit_wen_1 !== 1'b1 || rob_commit_wen_2 !== 1'b1 || rob_commit_slot_1 !== 5'd31 || rob_commit_slot_2 !== 5'd0) begin n_bad++; $display("FAIL wrap_commit got wen=%b%b slots=%0d/%0d want 11 31/0", rob_commit_wen_1, rob_commit_wen_2, rob_commit_slot_1, rob_commit_slot_2); end
        n_cmp++; if (rob_commit_rf_wdata_1 !== 32'hF00D || rob_commit_rf_wdata_2 !== 32'hCAFE) begin n_bad++; $display("FAIL wrap_data got %h/%h want f00d/cafe", rob_commit_rf_wdata_1, rob_commit_rf_wdata_2); end
        tick();
        n_cmp++; if (rob_count !== 6'd0 || rob_commit_slot_1 !== 5'd1) begin n_bad++; $display("FAIL wrap_head got count=%0d head=%0d want 0/1", rob_count, rob_commit_slot_1); end
    endtask

    task automatic test_reset_mid();
        alloc(1, 1, 8, 1, 1, 9);
        repeat (5) tick();
        idle();
        fill_a(q[1], 32'h1); fill_b(q[2], 32'h2); tick(); idle();
        fill_a(q[3], 32'h3); fill_b(q[4], 32'h4); tick(); idle();
        n_cmp++; if (rob_count !== 6'd10 || rob_commit_wen_1 !== 1'b0) begin n_bad++; $display("FAIL mid_pre got count=%0d wen1=%b want 10/0", rob_count, rob_commit_wen_1); end
        reset = 1; tick(); reset = 0;
        n_cmp++; if (rob_count !== 6'd0 || rob_commit_wen_1 !== 1'b0 || rob_commit_wen_2 !== 1'b0) begin n_bad++; $display("FAIL mid_reset got count=%0d wen=%b%b want 0/00", rob_count, rob_commit_wen_1, rob_commit_wen_2); end
        alloc(1, 1, 13, 1, 1, 14); fill_a(2, 32'hDEAD); #1;
        n_cmp++; if (rob_alloc_slot_0 !== 5'd0 || rob_alloc_slot_1 !== 5'd1) begin n_bad++; $display("FAIL mid_slots got %0d/%0d want 0/1", rob_alloc_slot_0, rob_alloc_slot_1); end
        tick(); idle(); tick();
        n_cmp++; if (rob_count !== 6'd2 || rob_commit_wen_1 !== 1'b0) begin n_bad++; $display("FAIL mid_stale got count=%0d wen1=%b want 2/0", rob_count, rob_commit_wen_1); end
    endtask

    task automatic test_random();
        int cand[$];
        int sa, sb, pa;
        bit e1, e2;
        for (int cyc = 0; cyc < 1200; cyc++) begin
            pa = ((cyc % 300) < 150) ? 60 : 20;
            idle(); sa = -1;
            alloc($urandom_range(0, 99) < pa, $urandom_range(0, 1) == 1, $urandom_range(0, 31),
                  $urandom_range(0, 99) < pa, $urandom_range(0, 1) == 1, $urandom_range(0, 31));
            cand.delete();
            foreach (q[i]) if (!m_filled[q[i]]) cand.push_back(q[i]);
            if (cand.size() > 0 && $urandom_range(0, 99) >= pa) begin
                sa = cand[$urandom_range(0, cand.size() - 1)];
                fill_a(sa, $urandom());
            end
            if (cand.size() > 1 && $urandom_range(0, 99) >= pa) begin
                sb = cand[$urandom_range(0, cand.size() - 1)];
                if (sb != sa) fill_b(sb, $urandom());
            end else if ($urandom_range(0, 7) == 0) begin
                sb = $urandom_range(0, ENTRIES - 1);
                if (!m_inq[sb]) fill_b(sb, $urandom());
            end
            #1;
            e1 = q.size() > 0 && m_filled[q[0]];
            e2 = e1 && q.size() > 1 && m_filled[q[1]];
            n_cmp++; if (rob_alloc_rdy !== (q.size() <= ENTRIES - 2)) begin n_bad++; $display("FAIL rnd_rdy c%0d got %b occ %0d", cyc, rob_alloc_rdy, q.size()); end
            n_cmp++; if (rob_count !== 6'(q.size())) begin n_bad++; $display("FAIL rnd_count c%0d got %0d want %0d", cyc, rob_count, q.size()); end
            n_cmp++; if (rob_commit_wen_1 !== e1 || rob_commit_wen_2 !== e2) begin n_bad++; $display("FAIL rnd_wens c%0d got %b%b want %b%b", cyc, rob_commit_wen_1, rob_commit_wen_2, e1, e2); end
            n_cmp++; if (rob_commit_slot_1 !== 5'(m_head) || rob_commit_slot_2 !== 5'((m_head + 1) % ENTRIES)) begin n_bad++; $display("FAIL rnd_cslots c%0d got %0d/%0d head %0d", cyc, rob_commit_slot_1, rob_commit_slot_2, m_head); end
            n_cmp++; if (rob_alloc_slot_0 !== 5'(m_tail) || rob_alloc_slot_1 !== 5'((m_tail + (rob_alloc_req_0 ? 1 : 0)) % ENTRIES)) begin n_bad++; $display("FAIL rnd_aslots c%0d got %0d/%0d tail %0d", cyc, rob_alloc_slot_0, rob_alloc_slot_1, m_tail); end
            n_cmp++; if (rob_commit_rf_wen_1 !== (e1 ? m_wen[q[0]] : 1'b0) || rob_commit_rf_wen_2 !== (e2 ? m_wen[q[1]] : 1'b0)) begin n_bad++; $display("FAIL rnd_rfwen c%0d got %b%b", cyc, rob_commit_rf_wen_1, rob_commit_rf_wen_2); end
            if (e1) begin
                n_cmp++; if (rob_commit_rf_waddr_1 !== m_waddr[q[0]] || rob_commit_rf_wdata_1 !== m_data[q[0]]) begin n_bad++; $display("FAIL rnd_c1 c%0d got %0d/%h want %0d/%h", cyc, rob_commit_rf_waddr_1, rob_commit_rf_wdata_1, m_waddr[q[0]], m_data[q[0]]); end
            end
            if (e2) begin
                n_cmp++; if (rob_commit_rf_waddr_2 !== m_waddr[q[1]] || rob_commit_rf_wdata_2 !== m_data[q[1]]) begin n_bad++; $display("FAIL rnd_c2 c%0d got %0d/%h want %0d/%h", cyc, rob_commit_rf_waddr_2, rob_commit_rf_wdata_2, m_waddr[q[1]], m_data[q[1]]); end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        m_head = 0; m_tail = 0;
        test_reset();
        test_pair_commit();
        test_single_alloc();
        test_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
